// File: rtl/led_status_pkg.sv
// Shared types and constants for the LED status arbiter: FSM states, source ids
// and the fixed-priority pick helper.
package led_status_pkg;

  localparam int N_REQ = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [2:0] ID_FAULT    = 3'd0;
  localparam logic [2:0] ID_COIN     = 3'd1;
  localparam logic [2:0] ID_SELECT   = 3'd2;
  localparam logic [2:0] ID_DISPENSE = 3'd3;
  localparam logic [2:0] ID_CHANGE   = 3'd4;
  localparam logic [2:0] ID_SOLDOUT  = 3'd5;
  localparam logic [2:0] ID_DONE     = 3'd6;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [2:0] prio_pick(input logic [N_REQ-1:0] p);
    logic [2:0] id;
    id = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (p[i]) id = 3'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/led_status_arbiter_sec_tick_gen.sv
// One-second tick generator: counts while enabled, emits a one-cycle tick on
// the terminal count, and restarts synchronously at every new grant.
module sec_tick_gen #(
  parameter int T_1S = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(T_1S);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_1S - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/led_status_arbiter.sv
// LED status arbiter: latches status requests, grants one at a time by fixed
// priority, holds each for HOLD_S seconds, and lets the fault source preempt.
module led_status_arbiter
  import led_status_pkg::*;
#(
  parameter int T_1S   = 50_000_000,
  parameter int HOLD_S = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             clr,
  output logic [N_REQ-1:0] state_oh,
  output logic [2:0]       active_id,
  output logic             busy
);

  localparam int SW = $clog2(HOLD_S + 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(HOLD_S - 1);

  state_t           state, state_n;
  logic [N_REQ-1:0] pend, pend_n, req_m, win_oh;
  logic [SW-1:0]    sec, sec_n;
  logic [2:0]       win;
  logic             grant, preempt, tick;
  logic [N_REQ-1:0] state_oh_n;
  logic [2:0]       active_id_n;
  logic             busy_n;

  sec_tick_gen #(.T_1S(T_1S)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (state == SHOW),
    .restart (grant),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state plus the pending/second bookkeeping that rides along with it.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    preempt = 1'b0;
    win     = prio_pick(pend);
    win_oh  = N_REQ'(1) << win;
    req_m   = req;
    if (state == SHOW) req_m[active_id] = 1'b0;

    case (state)
      IDLE: begin
        if (pend != '0) begin
          state_n = SHOW;
          grant   = 1'b1;
        end
      end
      SHOW: begin
        if (pend[ID_FAULT] && active_id != ID_FAULT) begin
          state_n = GAP;
          preempt = 1'b1;
        end else if (tick && sec == SEC_LAST) begin
          state_n = GAP;
        end
      end
      GAP: begin
        if (pend != '0) begin
          state_n = SHOW;
          grant   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (clr) begin
      state_n = (state == SHOW) ? GAP : IDLE;
      grant   = 1'b0;
      preempt = 1'b0;
    end

    // Clearing the winner after merging requests swallows a req held across the grant edge.
    pend_n = pend | req_m;
    if (preempt) pend_n[active_id] = 1'b1;
    if (grant)   pend_n = pend_n & ~win_oh;
    if (clr)     pend_n = '0;

    sec_n = sec;
    if (state_n != SHOW || grant) sec_n = '0;
    else if (tick)                sec_n = sec + SW'(1);
  end

  always_comb begin
    state_oh_n  = '0;
    active_id_n = 3'd0;
    busy_n      = 1'b0;
    if (grant) begin
      state_oh_n  = win_oh;
      active_id_n = win;
      busy_n      = 1'b1;
    end else if (state_n == SHOW) begin
      state_oh_n  = state_oh;
      active_id_n = active_id;
      busy_n      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= '0;
      sec       <= '0;
      state_oh  <= '0;
      active_id <= 3'd0;
      busy      <= 1'b0;
    end else begin
      pend      <= pend_n;
      sec       <= sec_n;
      state_oh  <= state_oh_n;
      active_id <= active_id_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed bench for led_status_arbiter with T_1S=4, HOLD_S=2 (8-cycle hold).
module tb_led_status_arbiter;

  logic       clk;
  logic       rst;
  logic [6:0] req;
  logic       clr;
  logic [6:0] state_oh;
  logic [2:0] active_id;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  led_status_arbiter #(.T_1S(4), .HOLD_S(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .clr       (clr),
    .state_oh  (state_oh),
    .active_id (active_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] eoh, input logic [2:0] eid,
                     input logic eb);
    checks++;
    assert (state_oh === eoh && active_id === eid && busy === eb)
    else begin
      failures++;
      $error("FAIL %s: got oh=%b id=%0d busy=%b, expected oh=%b id=%0d busy=%b",
             tag, state_oh, active_id, busy, eoh, eid, eb);
    end
  endtask

  task automatic show(input string tag, input int id, input int n);
    logic [6:0] oh;
    oh = 7'd1 << id;
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(tag, oh, 3'(id), 1'b1);
    end
  endtask

  task automatic zero(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(tag, 7'd0, 3'd0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    clr = 1'b0;
    repeat (3) cyc();
    chk("reset", 7'd0, 3'd0, 1'b0);
    rst = 1'b1;
    zero("idle_after_reset", 2);

    // Single pulse: 8 cycles of id 3, one GAP, then IDLE.
    req = 7'b0001000; cyc(); req = '0;
    chk("p1_latency", 7'd0, 3'd0, 1'b0);
    show("p1_show3", 3, 8);
    zero("p1_gap", 1);
    zero("p1_idle", 2);

    // Simultaneous requests: id 2 wins, then id 5 after one zero cycle.
    req = 7'b0100100; cyc(); req = '0;
    chk("p2_latency", 7'd0, 3'd0, 1'b0);
    show("p2_show2", 2, 8);
    zero("p2_gap", 1);
    show("p2_show5", 5, 8);
    zero("p2_end", 2);

    // Preemption of id 4 by fault at the third SHOW cycle.
    req = 7'b0010000; cyc(); req = '0;
    chk("p3_latency", 7'd0, 3'd0, 1'b0);
    show("p3_show4_pre", 4, 2);
    req = 7'b0000001; cyc(); req = '0;
    chk("p3_show4_3rd", 7'b0010000, 3'd4, 1'b1);
    zero("p3_preempt_gap", 1);
    show("p3_fault", 0, 8);
    zero("p3_gap2", 1);
    show("p3_reshow4", 4, 8);
    zero("p3_end", 2);

    // Clear during SHOW of id 1 with id 6 pending.
    req = 7'b0000010; cyc(); req = '0;
    chk("p4_latency", 7'd0, 3'd0, 1'b0);
    show("p4_show1", 1, 2);
    req = 7'b1000000; cyc(); req = '0;
    chk("p4_show1_req6", 7'b0000010, 3'd1, 1'b1);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("p4_clr_gap", 7'd0, 3'd0, 1'b0);
    zero("p4_no_id6", 4);
    req = 7'b0000100; clr = 1'b1; cyc(); req = '0; clr = 1'b0;
    chk("p4_clr_req", 7'd0, 3'd0, 1'b0);
    zero("p4_clr_req_none", 4);

    // Re-request of the active id neither extends nor re-shows.
    req = 7'b0001000; cyc(); req = '0;
    chk("p5_latency", 7'd0, 3'd0, 1'b0);
    show("p5_show3_a", 3, 3);
    req = 7'b0001000; cyc(); req = '0;
    chk("p5_rereq3", 7'b0001000, 3'd3, 1'b1);
    show("p5_show3_b", 3, 4);
    zero("p5_no_reshow3", 3);
    req = 7'b0000001; cyc(); req = '0;
    chk("p5_latency0", 7'd0, 3'd0, 1'b0);
    show("p5_show0_a", 0, 3);
    req = 7'b0000001; cyc(); req = '0;
    chk("p5_rereq0", 7'b0000001, 3'd0, 1'b1);
    show("p5_show0_b", 0, 4);
    zero("p5_no_restart0", 3);

    // Asynchronous reset mid-SHOW, then a normal request afterwards.
    req = 7'b0100000; cyc(); req = '0;
    chk("p6_latency", 7'd0, 3'd0, 1'b0);
    show("p6_show5", 5, 3);
    #2 rst = 1'b0;
    #1 chk("p6_async_rst", 7'd0, 3'd0, 1'b0);
    cyc();
    chk("p6_rst_held", 7'd0, 3'd0, 1'b0);
    rst = 1'b1;
    zero("p6_after_rst", 2);
    req = 7'b0000010; cyc(); req = '0;
    chk("p6_req1_latency", 7'd0, 3'd0, 1'b0);
    show("p6_show1", 1, 8);
    zero("p6_end", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_status_arbiter.md
# led_status_arbiter

Arbitration and sequencing controller for the vending machine's LED status indicator. Seven status sources raise requests; the block grants the indicator to one source at a time and drives the one-hot state-flag bus that selects which LED pattern rotates. Each granted status is held for a fixed minimum display time. The fault source (index 0) may preempt any other status. It sits between the vending FSM event outputs and the LED pattern driver.

## Interface
- `N_REQ`, 7: number of status sources; fixed at 7 to match the LED driver's state-flag inputs.
- `T_1S`, 50_000_000: clock cycles per one-second tick (50 MHz clock); must be ≥2.
- `HOLD_S`, 3: display seconds per grant; must be ≥1.
- `clk`  in  1  clock, 50 MHz.
- `rst`  in  1  asynchronous reset, active-low.
- `req`  in  N_REQ  status requests; any cycle high latches the request. Index 0 is fault and has the highest priority.
- `clr`  in  1  synchronous cancel of all pending and active status.
- `state_oh`  out  N_REQ  one-hot (or all-zero) state flags to the LED driver; registered.
- `active_id`  out  3  index of the granted source; 0 when nothing is shown.
- `busy`  out  1  high in SHOW.

## Operation
- **Pending register** `pend[N_REQ-1:0]`:
  - `req[i]` high at edge n sets `pend[i]` at edge n.
  - A request for the currently active id during SHOW is ignored; it neither sets pend nor restarts the hold.
- **Arbitration:** fixed priority, lowest index wins.
- **States:**
  - IDLE
    - `pend` != 0 → SHOW. Grant the winner, clear its pend bit, load `state_oh`/`active_id`, and restart the tick counter.
    - Otherwise stay in IDLE.
  - SHOW
    - Counts `cnt` 0..T_1S-1 and `sec` 0..HOLD_S-1.
    - At `cnt==T_1S-1 && sec==HOLD_S-1` → GAP.
    - If `pend[0]` is set and `active_id` != 0 → GAP immediately (preemption). In this case the preempted id's pend bit is set again.
  - GAP
    - One cycle with `state_oh`=0 and `active_id`=0.
    - `pend` != 0 → SHOW (grant as in IDLE).
    - Otherwise → IDLE.
- **Clear:**
  - `clr` high in any state → `pend` cleared and `state_oh`=0.
  - The next state is GAP if the current state is SHOW; otherwise IDLE.
  - `clr` wins over a simultaneous `req`; requests in that cycle are dropped.
- **Widths:**
  - `cnt` is $clog2(T_1S) bits (26 at default).
  - `sec` is $clog2(HOLD_S+1) bits.
  - Both counters are compared against equality terminal values and never wrap silently.
- **Reset:**
  - Values: state=IDLE; `pend`, `cnt`, `sec` = 0; `state_oh`=0, `active_id`=0, `busy`=0.
  - Reset is honoured mid-SHOW with no completion of the hold.

## Timing
- **Request latency:** `req[i]` sampled at edge n with the block in IDLE → `state_oh[i]` high after edge n+1.
- **Display length:** every non-preempted grant shows exactly HOLD_S·T_1S cycles.
- **Between grants:** exactly one all-zero cycle (GAP) separates consecutive grants, so the LED driver always sees its all-zero reset pattern between statuses.
- **Preemption:** `req[0]` at edge n during SHOW of id k → GAP after edge n+1, then `state_oh[0]` after edge n+2. Id k is reshown later for a full hold.
- **Registered outputs:** all outputs are registered; there are no combinational paths from `req` or `clr` to outputs.

## Structure
- **Package `led_status_pkg`:**
  - State enum {IDLE, SHOW, GAP}.
  - `N_REQ`.
  - Status id constants: ID_FAULT=0, ID_COIN=1, ID_SELECT=2, ID_DISPENSE=3, ID_CHANGE=4, ID_SOLDOUT=5, ID_DONE=6.
- **Sub-module `sec_tick_gen`:**
  - Parameter T_1S.
  - Synchronous restart input, and a one-cycle tick output at `cnt==T_1S-1`.
  - Instanced once; `sec` counting stays in the arbiter.

## Test plan
Bench parameters: T_1S=4, HOLD_S=2, so a hold is 8 cycles.
1. **Single pulse:** `req[3]` pulse at edge 10 → `state_oh`=7'b0001000 and `active_id`=3 after edges 11–18; GAP (all zero) after edge 19; IDLE with `busy`=0 after edge 20.
2. **Simultaneous requests:** `req[2]` and `req[5]` together at edge 10 → id 2 for 8 cycles, one zero cycle, then id 5 for 8 cycles.
3. **Preemption:**
   - Stimulus: id 4 showing, `req[0]` at the 3rd SHOW cycle.
   - Response: one zero cycle, then 7'b0000001 for 8 cycles, then a zero cycle, then id 4 for a full 8 cycles.
4. **Clear:**
   - Stimulus: `clr` during SHOW of id 1 with `pend[6]` set.
   - Response: GAP, then IDLE; id 6 is never shown.
   - Also: `clr` and `req[2]` in the same cycle → nothing is shown.
5. **Re-request of active id:** `req[3]` re-pulsed during the id-3 show → no extension and no re-show afterwards. `req[0]` during an id-0 show → no restart.
6. **Asynchronous reset:** `rst` low mid-SHOW → all outputs 0 immediately. After release, `req[1]` shows normally with 2-cycle latency.
